// File: rtl/exu_lsu_ctrl.sv
// Load/store sequencer between the execute stage and the data memory bus.
// Forms byte lanes, extends load data, and flags misaligned or timed-out accesses.
module exu_lsu_ctrl #(
  parameter int ADDR_LEN = 32,
  parameter int WORD_LEN = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_i,
  input  logic                rw_i,
  input  logic [2:0]          funct3_i,
  input  logic [ADDR_LEN-1:0] addr_i,
  input  logic [WORD_LEN-1:0] wr_data_i,
  input  logic [4:0]          wb_addr_i,
  output logic                lsu_wait_,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [3:0]          mem_be_o,
  output logic [ADDR_LEN-1:0] mem_addr_o,
  output logic [WORD_LEN-1:0] mem_wr_data_o,
  input  logic [WORD_LEN-1:0] mem_rd_data_i,
  input  logic                mem_busy_,
  output logic                wr_en_,
  output logic [4:0]          wr_addr_o,
  output logic [WORD_LEN-1:0] wr_data_o,
  output logic                misalign_o,
  output logic                bus_err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [WORD_LEN-1:0] wd_q, wd_d;
  logic [4:0]          wb_q, wb_d;
  logic [WORD_LEN-1:0] rd_q, rd_d;
  logic                mis_q, mis_d;
  logic                err_q, err_d;

  logic                legal, aligned, can_take, accept;
  logic [3:0]          be_new;
  logic [WORD_LEN-1:0] wd_new;
  logic [WORD_LEN-1:0] lane;
  logic [WORD_LEN-1:0] ld_ext;

  always_comb begin
    legal = 1'b0;
    unique case (funct3_i)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~rw_i;
      default:                legal = 1'b0;
    endcase
    aligned = 1'b1;
    be_new  = 4'b1111;
    wd_new  = wr_data_i;
    unique case (funct3_i[1:0])
      2'b00: begin
        be_new = 4'b0001 << addr_i[1:0];
        wd_new = {4{wr_data_i[7:0]}};
      end
      2'b01: begin
        aligned = ~addr_i[0];
        be_new  = addr_i[1] ? 4'b1100 : 4'b0011;
        wd_new  = {2{wr_data_i[15:0]}};
      end
      default: aligned = (addr_i[1:0] == 2'b00);
    endcase
  end

  // Lane select and extension of the returning read word.
  always_comb begin
    lane   = mem_rd_data_i >> {addr_q[1:0], 3'b000};
    ld_ext = lane;
    unique case (f3_q)
      3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_ext = {24'd0, lane[7:0]};
      3'b101:  ld_ext = {16'd0, lane[15:0]};
      default: ld_ext = lane;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    f3_d     = f3_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wd_d     = wd_q;
    wb_d     = wb_q;
    rd_d     = rd_q;
    mis_d    = 1'b0;
    err_d    = 1'b0;
    can_take = (state_q == IDLE) || (state_q == RESP);
    accept   = can_take & req_i & legal & aligned;
    if (can_take) begin
      state_d = IDLE;
      if (accept) begin
        state_d = BUS;
        cnt_d   = '0;
        rw_d    = rw_i;
        f3_d    = funct3_i;
        addr_d  = addr_i;
        be_d    = be_new;
        wd_d    = wd_new;
        wb_d    = wb_addr_i;
      end else if (req_i && legal) begin
        mis_d = 1'b1;
      end
    end else if (state_q == BUS) begin
      if (mem_busy_) begin
        state_d = RESP;
        if (!rw_q) rd_d = ld_ext;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wd_q    <= '0;
      wb_q    <= 5'd0;
      rd_q    <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign mem_req_o     = (state_q == BUS);
  assign lsu_wait_     = ~(accept | (state_q == BUS));
  assign mem_we_o      = rw_q;
  assign mem_be_o      = be_q;
  assign mem_addr_o    = {addr_q[ADDR_LEN-1:2], 2'b00};
  assign mem_wr_data_o = wd_q;
  assign wr_en_        = ~((state_q == RESP) & ~rw_q & (wb_q != 5'd0));
  assign wr_addr_o     = wb_q;
  assign wr_data_o     = rd_q;
  assign misalign_o    = mis_q;
  assign bus_err_o     = err_q;

endmodule

// File: tb/tb_exu_lsu_ctrl.sv
// Directed and randomized checks of exu_lsu_ctrl against a lane/extension model.
// All driving happens 1ns after a rising edge; checks follow 1ns later.
module tb_exu_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, rw_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wr_data_i;
  logic [4:0]  wb_addr_i;
  logic        lsu_wait_, mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wr_data_o, mem_rd_data_i;
  logic        mem_busy_, wr_en_;
  logic [4:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic        misalign_o, bus_err_o;

  int n_vec = 0;
  int n_err = 0;

  localparam int TMO = 255;

  exu_lsu_ctrl #(.ADDR_LEN(32), .WORD_LEN(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .rw_i(rw_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wr_data_i(wr_data_i),
    .wb_addr_i(wb_addr_i), .lsu_wait_(lsu_wait_),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_rd_data_i(mem_rd_data_i), .mem_busy_(mem_busy_),
    .wr_en_(wr_en_), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] m_be(input logic [2:0] f3,
                                      input logic [31:0] a);
    int sz = 1 << f3[1:0];
    if (sz == 1) return 4'(1 << (a % 4));
    if (sz == 2) return 4'(3 << (a % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3,
                                       input logic [31:0] d);
    if (f3[1:0] == 2'd0) return (d % 256) * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3,
                                       input logic [31:0] a,
                                       input logic [31:0] rd);
    longint v = longint'(rd >> (8 * (a % 4)));
    longint lim;
    if (f3[1:0] == 2'd2) return rd;
    lim = (f3[1:0] == 2'd0) ? 256 : 65536;
    v = v % lim;
    if (!f3[2] && v >= lim / 2) v = v - lim;
    return 32'(v);
  endfunction

  task automatic idle_inputs;
    req_i = 0; rw_i = 0; funct3_i = 0; addr_i = 0;
    wr_data_i = 0; wb_addr_i = 0; mem_busy_ = 0; mem_rd_data_i = 0;
  endtask

  task automatic drive(input bit rw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] wb);
    req_i = 1; rw_i = rw; funct3_i = f3; addr_i = a;
    wr_data_i = wd; wb_addr_i = wb;
  endtask

  // Full transfer from IDLE; returns in IDLE one cycle after RESP.
  task automatic xfer(input bit rw, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [4:0] wb, input logic [31:0] rd,
                      input int nb);
    drive(rw, f3, a, wd, wb);
    mem_busy_ = 0;
    #1 chk("accept_wait", lsu_wait_, 0);
    tick;
    req_i = 0;
    #1;
    chk("bus_req", mem_req_o, 1);
    chk("bus_we", mem_we_o, rw);
    chk("bus_be", mem_be_o, m_be(f3, a));
    chk("bus_addr", mem_addr_o, a & 32'hFFFF_FFFC);
    if (rw) chk("bus_wdata", mem_wr_data_o, m_wd(f3, wd));
    chk("bus_wait", lsu_wait_, 0);
    for (int i = 0; i < nb; i++) begin
      tick;
      chk("busy_req", mem_req_o, 1);
      chk("busy_wait", lsu_wait_, 0);
    end
    mem_busy_ = 1;
    mem_rd_data_i = rd;
    tick;
    mem_busy_ = 0;
    mem_rd_data_i = $urandom;
    #1;
    chk("resp_req", mem_req_o, 0);
    chk("resp_wait", lsu_wait_, 1);
    chk("resp_wren", wr_en_, (!rw && wb != 0) ? 0 : 1);
    if (!rw) begin
      chk("resp_waddr", wr_addr_o, wb);
      chk("resp_wdata", wr_data_o, m_ld(f3, a, rd));
    end
    tick;
    chk("post_wren", wr_en_, 1);
    chk("post_req", mem_req_o, 0);
  endtask

  task automatic misal(input bit rw, input logic [2:0] f3,
                       input logic [31:0] a);
    drive(rw, f3, a, 32'h5555_AAAA, 5'd3);
    #1 chk("mis_wait", lsu_wait_, 1);
    tick;
    req_i = 0;
    #1;
    chk("mis_pulse", misalign_o, 1);
    chk("mis_req", mem_req_o, 0);
    tick;
    chk("mis_clear", misalign_o, 0);
    chk("mis_req2", mem_req_o, 0);
  endtask

  initial begin
    int k;
    bit seen;
    logic [2:0] f3;
    bit rw;
    logic [31:0] a;
    logic [2:0] ldf [5];
    ldf = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    idle_inputs();
    rst = 1;
    tick;
    tick;
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_be", mem_be_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wr_data_o, 0);
    chk("rst_waddr", wr_addr_o, 0);
    chk("rst_rdata", wr_data_o, 0);
    chk("rst_mis", misalign_o, 0);
    chk("rst_err", bus_err_o, 0);
    chk("rst_wait", lsu_wait_, 1);
    chk("rst_wren", wr_en_, 1);
    rst = 0;
    tick;

    xfer(1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd7, 32'h0, 0);
    xfer(0, 3'b000, 32'h103, 32'h0, 5'd5, 32'h8000_0000, 0);
    chk("lb_value", wr_data_o, 32'hFFFF_FF80);
    xfer(0, 3'b100, 32'h103, 32'h0, 5'd5, 32'h8000_0000, 0);
    chk("lbu_value", wr_data_o, 32'h0000_0080);
    xfer(1, 3'b001, 32'h102, 32'h0000_1234, 5'd1, 32'h0, 0);
    misal(0, 3'b001, 32'h101);
    xfer(0, 3'b010, 32'h40, 32'h0, 5'd9, 32'h1234_5678, 3);
    xfer(0, 3'b001, 32'h42, 32'h0, 5'd0, 32'hF00D_8001, 1);

    // Illegal funct3: no bus cycle, no pulse.
    drive(0, 3'b011, 32'h80, 32'h0, 5'd4);
    #1 chk("ill_wait", lsu_wait_, 1);
    tick;
    req_i = 0;
    #1;
    chk("ill_req", mem_req_o, 0);
    chk("ill_mis", misalign_o, 0);
    chk("ill_wren", wr_en_, 1);
    tick;

    // Timeout with memory held busy.
    drive(0, 3'b010, 32'h300, 32'h0, 5'd6);
    tick;
    req_i = 0;
    k = 1;
    seen = 0;
    while (k < TMO + 20 && !seen) begin
      #1;
      if (bus_err_o) seen = 1;
      else begin
        tick;
        k++;
      end
    end
    chk("tmo_seen", seen, 1);
    chk("tmo_cycles", k, TMO + 1);
    chk("tmo_req", mem_req_o, 0);
    chk("tmo_wait", lsu_wait_, 1);
    chk("tmo_wren", wr_en_, 1);
    tick;
    chk("tmo_pulse_end", bus_err_o, 0);
    chk("tmo_idle_req", mem_req_o, 0);

    // Back-to-back: SW requested during LW's RESP.
    drive(0, 3'b010, 32'h200, 32'h0, 5'd12);
    tick;
    req_i = 0;
    mem_busy_ = 1;
    mem_rd_data_i = 32'hCAFE_0001;
    tick;
    mem_busy_ = 0;
    drive(1, 3'b010, 32'h204, 32'h0BAD_F00D, 5'd0);
    #1;
    chk("b2b_wait", lsu_wait_, 0);
    chk("b2b_wren", wr_en_, 0);
    chk("b2b_rdata", wr_data_o, 32'hCAFE_0001);
    tick;
    req_i = 0;
    #1;
    chk("b2b_req", mem_req_o, 1);
    chk("b2b_we", mem_we_o, 1);
    chk("b2b_addr", mem_addr_o, 32'h204);
    chk("b2b_wdata", mem_wr_data_o, 32'h0BAD_F00D);
    mem_busy_ = 1;
    tick;
    mem_busy_ = 0;
    #1 chk("b2b_st_wren", wr_en_, 1);
    tick;

    // Reset while in BUS.
    drive(0, 3'b010, 32'h400, 32'h0, 5'd8);
    tick;
    req_i = 0;
    rst = 1;
    mem_busy_ = 1;
    tick;
    rst = 0;
    mem_busy_ = 0;
    #1;
    chk("rstbus_req", mem_req_o, 0);
    chk("rstbus_wren", wr_en_, 1);
    chk("rstbus_err", bus_err_o, 0);
    chk("rstbus_mis", misalign_o, 0);
    tick;
    chk("rstbus_wren2", wr_en_, 1);
    chk("rstbus_req2", mem_req_o, 0);

    for (int t = 0; t < 60; t++) begin
      rw = 1'($urandom_range(0, 1));
      f3 = rw ? 3'($urandom_range(0, 2)) : ldf[$urandom_range(0, 4)];
      a  = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 5) == 0 && f3[1:0] != 2'd0) begin
        a[0] = 1'b1;
        misal(rw, f3, a);
      end else begin
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
        xfer(rw, f3, a, $urandom, 5'($urandom), $urandom,
             $urandom_range(0, 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
